logic_unit_pipe: RTL

Parametrised, pipelined bitwise logic unit generalising the team's two-input AND/NAND and OR/NOR gate pair. It operates on WIDTH-bit operands with a runtime-selected operation, including two reduction modes. Data moves through STAGES register stages under valid/ready flow control. A wrapping counter records completed results for the SimShop benches.

---
 rtl/logic_unit_pkg.sv | 42 ++++
 rtl/logic_pipe_stage.sv | 38 +++
 rtl/logic_unit_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and the reference operation for the pipelined logic unit.
package logic_unit_pkg;

    localparam int unsigned OP_W  = 3;
    // Widest operand compute() handles; callers zero-extend and keep the low bits.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        OpAnd  = 3'd0,
        OpNand = 3'd1,
        OpOr   = 3'd2,
        OpNor  = 3'd3,
        OpXor  = 3'd4,
        OpXnor = 3'd5,
        OpRand = 3'd6,
        OpRor  = 3'd7
    } op_e;

    // Result for a w-bit operation; bits at and above w are returned as zero.
    function automatic logic [MAX_W-1:0] compute(input op_e op,
                                                 input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        case (op)
            OpAnd:   r = a & b;
            OpNand:  r = ~(a & b);
            OpOr:    r = a | b;
            OpNor:   r = ~(a | b);
            OpXor:   r = a ^ b;
            OpXnor:  r = ~(a ^ b);
            // Bits outside the operand are forced so they do not affect the reduction.
            OpRand:  r = {{(MAX_W-1){1'b0}}, &(a | ~mask)};
            OpRor:   r = {{(MAX_W-1){1'b0}}, |(a & mask)};
            default: r = '0;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register stage; ready depends only on occupancy and downstream ready.
module logic_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Advance when empty or when the successor takes the current content.
    always_comb begin
        in_ready  = !valid_q || out_ready;
        out_valid = valid_q;
        out_data  = data_q;
    end

    // Occupancy and data register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: combinational op, STAGES-deep register chain, result counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_count
);

    logic [MAX_W-1:0] op_full;
    logic [WIDTH-1:0] op_res;
    logic             unused_op_hi;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat [STAGES];

    logic [CNT_W-1:0] cnt_q;
    logic             out_hs;

    // Operation result from the current operands.
    always_comb begin
        op_full      = compute(op_e'(in_op), MAX_W'(in_a), MAX_W'(in_b), WIDTH);
        op_res       = op_full[WIDTH-1:0];
        unused_op_hi = ^op_full;
    end

    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             stg_valid;
        logic [WIDTH-1:0] stg_data;

        if (k == 0) begin : g_first
            assign stg_valid = in_valid;
            assign stg_data  = op_res;
        end else begin : g_rest
            assign stg_valid = vld[k-1];
            assign stg_data  = dat[k-1];
        end

        logic_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (stg_valid),
            .in_ready  (rdy[k]),
            .in_data   (stg_data),
            .out_valid (vld[k]),
            .out_ready (rdy[k+1]),
            .out_data  (dat[k])
        );
    end

    // Port view of the chain; in_ready is held low during reset.
    always_comb begin
        in_ready   = rst_n && rdy[0];
        out_valid  = vld[STAGES-1];
        out_data   = dat[STAGES-1];
        out_hs     = vld[STAGES-1] && out_ready;
        done_count = cnt_q;
    end

    // Completed-result counter; clear wins over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_q <= '0;
        end else if (out_hs) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
